bstep_preact_accum: RTL

Serial pre-activation accumulator for the binary-step activation path. Accepts one (sample, weight) pair per handshake and forms a signed dot product plus bias. At end-of-vector it rescales and saturates the sum to a 6-bit signed pre-activation value, which is handed downstream through a valid/ready port. The output feeds the 6-bit binary-step activation stage directly; that stage's `In[5:0]` connects to `out_data`.

---
 rtl/bstep_pkg.sv | 19 +
 rtl/bstep_shift_sat.sv | 32 +++
 rtl/bstep_preact_accum.sv | 107 ++++++++++
 3 files changed

// File: rtl/bstep_pkg.sv
// Shared definitions for the binary-step activation path: default widths,
// accumulator sizing and the accumulator FSM state type.
package bstep_pkg;

  localparam int unsigned DEF_DW       = 6;
  localparam int unsigned DEF_SHIFT    = 5;
  localparam int unsigned DEF_N_INPUTS = 8;

  // Room for N full-width products plus a sign bit of headroom for the bias.
  function automatic int unsigned acc_width(input int unsigned dw, input int unsigned n_inputs);
    return 2 * dw + $clog2(n_inputs) + 1;
  endfunction

  typedef enum logic {
    ACC = 1'b0,
    OUT = 1'b1
  } state_e;

endpackage

// File: rtl/bstep_shift_sat.sv
// Arithmetic right shift (floor) followed by signed saturation to DW bits.
module bstep_shift_sat #(
  parameter int unsigned ACC_W = 16,
  parameter int unsigned DW    = 6,
  parameter int unsigned SHIFT = 5
) (
  input  logic [ACC_W-1:0] acc_in,
  output logic [DW-1:0]    sat_data,
  output logic             sat_flag
);

  localparam int unsigned PAD = ACC_W - DW + 1;
  localparam logic signed [ACC_W-1:0] MAX_V = {{PAD{1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V = {{PAD{1'b1}}, {(DW-1){1'b0}}};

  logic signed [ACC_W-1:0] r;

  assign r = $signed(acc_in) >>> SHIFT;

  always_comb begin
    sat_data = r[DW-1:0];
    sat_flag = 1'b0;
    if (r > MAX_V) begin
      sat_data = MAX_V[DW-1:0];
      sat_flag = 1'b1;
    end else if (r < MIN_V) begin
      sat_data = MIN_V[DW-1:0];
      sat_flag = 1'b1;
    end
  end

endmodule

// File: rtl/bstep_preact_accum.sv
// Serial signed dot-product-plus-bias accumulator producing a saturated
// DW-bit pre-activation value over a registered valid/ready output.
module bstep_preact_accum
  import bstep_pkg::*;
#(
  parameter int unsigned N_INPUTS = DEF_N_INPUTS,
  parameter int unsigned DW       = DEF_DW,
  parameter int unsigned SHIFT    = DEF_SHIFT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic [DW-1:0] in_weight,
  input  logic [DW-1:0] in_bias,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_sat,
  output logic          out_len_err
);

  localparam int unsigned ACC_W = acc_width(DW, N_INPUTS);
  localparam int unsigned CNT_W = $clog2(N_INPUTS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_INPUTS - 1);

  state_e                  state;
  logic [CNT_W-1:0]        cnt;
  logic signed [ACC_W-1:0] acc;

  logic signed [2*DW-1:0]  data_x;
  logic signed [2*DW-1:0]  weight_x;
  logic signed [2*DW-1:0]  prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] bias_ext;
  logic signed [ACC_W-1:0] base;
  logic signed [ACC_W-1:0] next_acc;
  logic [DW-1:0]           sat_data;
  logic                    sat_flag;
  logic                    beat;
  logic                    term;

  // Operands widened first so the product is computed at full 2*DW precision.
  assign data_x   = {{DW{in_data[DW-1]}}, in_data};
  assign weight_x = {{DW{in_weight[DW-1]}}, in_weight};
  assign prod     = data_x * weight_x;
  assign prod_ext = {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
  assign bias_ext = {{(ACC_W-DW){in_bias[DW-1]}}, in_bias};
  assign base     = (cnt == '0) ? (bias_ext <<< SHIFT) : acc;
  assign next_acc = base + prod_ext;

  assign beat = in_valid && in_ready;
  assign term = in_last || (cnt == LAST_CNT);

  bstep_shift_sat #(
    .ACC_W (ACC_W),
    .DW    (DW),
    .SHIFT (SHIFT)
  ) u_shift_sat (
    .acc_in   (next_acc),
    .sat_data (sat_data),
    .sat_flag (sat_flag)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ACC;
      cnt         <= '0;
      acc         <= '0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_sat     <= 1'b0;
      out_len_err <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (beat) begin
            acc <= next_acc;
            if (term) begin
              cnt         <= '0;
              out_data    <= sat_data;
              out_sat     <= sat_flag;
              out_len_err <= !in_last;
              out_valid   <= 1'b1;
              in_ready    <= 1'b0;
              state       <= OUT;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ACC;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule
